within_stim_gen: RTL

Programmable stimulus generator for the SVA `within` regression benches. Each accepted configuration produces one outer window, marked by a `start_outer` pulse and an `end_outer` pulse, plus one inner `inner_event` burst at a programmable offset and length. At the end of the run it reports whether the burst fell entirely inside the window. It is the driving end of the same interface the `within` property checkers observe, so benches can produce both contained and violating patterns deterministically.

---
 rtl/within_stim_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/within_stim_gen.sv
// Stimulus generator for `within` property benches: one outer window plus one
// inner burst per accepted configuration, with a containment verdict per run.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for cfg_valid; cfg_ready high, event outputs low
// S_RUN  | stepping cycle index k from 0 to k_last, driving events
module within_stim_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_outer_len,
  input  logic [CNT_W-1:0] cfg_inner_off,
  input  logic [CNT_W-1:0] cfg_inner_len,
  output logic             start_outer,
  output logic             end_outer,
  output logic             outer_active,
  output logic             inner_event,
  output logic             busy,
  output logic             done,
  output logic             contained
);

  localparam int KW = CNT_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [KW-1:0] r_len;
  logic [KW-1:0] r_off;
  logic [KW-1:0] r_end;
  logic [KW-1:0] r_k_last;
  logic          r_has_inner;

  logic          w_accept;
  logic [KW-1:0] w_in_len;
  logic [KW-1:0] w_in_off;
  logic [KW-1:0] w_in_end;
  logic          w_in_has;
  logic [KW-1:0] w_in_k_last;
  logic          w_in_contained;
  logic [KW-1:0] w_k_next;

  // All arithmetic is one bit wider than the fields so off+len-1 never wraps.
  assign w_in_len       = (cfg_outer_len == '0) ? KW'(1) : KW'(cfg_outer_len);
  assign w_in_off       = KW'(cfg_inner_off);
  assign w_in_end       = w_in_off + KW'(cfg_inner_len) - KW'(1);
  assign w_in_has       = (cfg_inner_len != '0);
  assign w_in_k_last    = (w_in_has && (w_in_end > w_in_len)) ? w_in_end : w_in_len;
  assign w_in_contained = w_in_has && (w_in_end <= w_in_len);
  assign w_accept       = (r_state == S_IDLE) && cfg_valid;
  assign w_k_next       = r_k + KW'(1);

  // Outputs are registered from the index of the cycle being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_len        <= '0;
      r_off        <= '0;
      r_end        <= '0;
      r_k_last     <= '0;
      r_has_inner  <= 1'b0;
      cfg_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      contained    <= 1'b0;
      start_outer  <= 1'b0;
      end_outer    <= 1'b0;
      outer_active <= 1'b0;
      inner_event  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_RUN;
            r_k          <= '0;
            r_len        <= w_in_len;
            r_off        <= w_in_off;
            r_end        <= w_in_end;
            r_k_last     <= w_in_k_last;
            r_has_inner  <= w_in_has;
            cfg_ready    <= 1'b0;
            busy         <= 1'b1;
            contained    <= w_in_contained;
            start_outer  <= 1'b1;
            end_outer    <= 1'b0;
            outer_active <= 1'b1;
            inner_event  <= w_in_has && (w_in_off == '0);
          end else begin
            start_outer  <= 1'b0;
            end_outer    <= 1'b0;
            outer_active <= 1'b0;
            inner_event  <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_k == r_k_last) begin
            r_state      <= S_IDLE;
            cfg_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            contained    <= r_has_inner && (r_end <= r_len);
            start_outer  <= 1'b0;
            end_outer    <= 1'b0;
            outer_active <= 1'b0;
            inner_event  <= 1'b0;
          end else begin
            r_k          <= w_k_next;
            start_outer  <= 1'b0;
            end_outer    <= (w_k_next == r_len);
            outer_active <= (w_k_next <= r_len);
            inner_event  <= r_has_inner && (w_k_next >= r_off) && (w_k_next <= r_end);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
